// File: rtl/mux_scan_serializer_pkg.sv
// Shared definitions for the select-tree scan serializer.
// Widths here are also used by the 32:1 mux tree.
package mux_scan_serializer_pkg;

  localparam int SEL_W = 5;
  localparam int WIDTH = 1 << SEL_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/mux_scan_serializer_if.sv
// Load, mux-tree and serial-stream signals of the scan serializer.
// slave = serializer side, master = environment side.
interface mux_scan_serializer_if;
  import mux_scan_serializer_pkg::*;

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [SEL_W-1:0] load_len;
  logic             load_msb_first;
  logic             abort;
  logic [WIDTH-1:0] mux_inp;
  logic [SEL_W-1:0] mux_sel;
  logic             mux_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_data;
  logic             ser_last;
  logic             busy;

  modport slave (
    input  load_valid, load_data,
    input  load_len, load_msb_first,
    input  abort, mux_out, ser_ready,
    output load_ready, mux_inp, mux_sel,
    output ser_valid, ser_data,
    output ser_last, busy
  );

  modport master (
    output load_valid, load_data,
    output load_len, load_msb_first,
    output abort, mux_out, ser_ready,
    input  load_ready, mux_inp, mux_sel,
    input  ser_valid, ser_data,
    input  ser_last, busy
  );

endinterface

// File: rtl/mux_scan_serializer_counter.sv
// Loadable up/down select counter with terminal detect.
// Terminal index is 0 when descending, len when ascending.
module mux_scan_counter
  import mux_scan_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [SEL_W-1:0] load_val_i,
  input  logic             step_i,
  input  logic             dir_i,
  input  logic [SEL_W-1:0] len_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             term_o
);

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;

  always_comb begin
    sel_d = sel_q;
    if (load_i) begin
      sel_d = load_val_i;
    end else if (step_i) begin
      sel_d = dir_i ? sel_q - 1'b1
                    : sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel_o  = sel_q;
  assign term_o = dir_i ? (sel_q == '0)
                        : (sel_q == len_i);

endmodule

// File: rtl/mux_scan_serializer.sv
// Holds a word on the mux tree and scans its select range,
// returning the tree output as a valid/ready serial stream.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  mux_scan_serializer_if.slave bus
);

  state_e           state_q, state_d;
  logic             load_ready_q, load_ready_d;
  logic [WIDTH-1:0] mux_inp_q;
  logic [SEL_W-1:0] len_q;
  logic             dir_q;
  logic             load_hs;
  logic             step;
  logic             term;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] start_sel;

  assign start_sel = bus.load_msb_first ? bus.load_len
                                        : '0;

  mux_scan_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_hs),
    .load_val_i (start_sel),
    .step_i     (step),
    .dir_i      (dir_q),
    .len_i      (len_q),
    .sel_o      (sel),
    .term_o     (term)
  );

  always_comb begin
    state_d      = state_q;
    load_ready_d = load_ready_q;
    load_hs      = 1'b0;
    step         = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready_d = 1'b1;
        if (bus.load_valid && load_ready_q) begin
          load_hs      = 1'b1;
          state_d      = SHIFT;
          load_ready_d = 1'b0;
        end
      end
      SHIFT: begin
        // a beat taken alongside abort still counts
        if ((bus.ser_ready && term) || bus.abort) begin
          state_d      = IDLE;
          load_ready_d = 1'b1;
        end else if (bus.ser_ready) begin
          step = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      load_ready_q <= 1'b0;
      mux_inp_q    <= '0;
      len_q        <= '0;
      dir_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ready_q <= load_ready_d;
      if (load_hs) begin
        mux_inp_q <= bus.load_data;
        len_q     <= bus.load_len;
        dir_q     <= bus.load_msb_first;
      end
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.mux_inp    = mux_inp_q;
  assign bus.mux_sel    = sel;
  assign bus.ser_valid  = (state_q == SHIFT);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.ser_data   = bus.mux_out;
  assign bus.ser_last   = (state_q == SHIFT) & term;

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
- Sequencer stage directly upstream of the team's 32:1 select tree (the 5-bit-select mux built from 2:1 cells).
- Accepts a 32-bit word over a valid/ready load interface and holds it on the tree's data inputs.
- Steps the tree's select through a programmable index range and returns the selected bit as a serial stream with valid/ready handshake.
- Turns the combinational mux into a parallel-to-serial channel scanner.

Parameters:
- WIDTH, 32, data word width; must equal 2**SEL_W.
- SEL_W, 5, select width driven to the mux tree.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  load word offered.
- load_ready  output  1  block can accept a load.
- load_data  input  WIDTH  word to scan.
- load_len  input  SEL_W  number of bits minus one (0 = 1 bit, 31 = 32 bits).
- load_msb_first  input  1  1: index sequence descends from load_len to 0; 0: ascends from 0 to load_len.
- abort  input  1  synchronous cancel of the current scan.
- mux_inp  output  WIDTH  registered word driven to the mux tree data inputs.
- mux_sel  output  SEL_W  registered select driven to the mux tree.
- mux_out  input  1  combinational result returned from the mux tree.
- ser_valid  output  1  serial bit valid.
- ser_ready  input  1  downstream accepts the bit.
- ser_data  output  1  equals mux_out (combinational pass-through).
- ser_last  output  1  final bit of the word.
- busy  output  1  high in SHIFT.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE.
  - load_ready=0, mux_inp=0, mux_sel=0, ser_valid=0, ser_last=0, busy=0.
  - Internal count=0, len=0, dir=0.
- load_ready is registered. It rises on the first clk edge after rst_n deasserts and is 1 whenever state=IDLE.
- State IDLE:
  - load handshake (load_valid & load_ready) latches mux_inp<=load_data, len<=load_len, dir<=load_msb_first.
  - On that handshake: mux_sel<=(load_msb_first ? load_len : 0); state<=SHIFT; load_ready<=0.
  - abort is ignored in IDLE.
- State SHIFT:
  - ser_valid=1, busy=1.
  - ser_data=mux_out, combinational from mux_sel through the tree; no extra latency.
  - ser_last=1 when the current index is the final one: mux_sel==0 if dir=1, mux_sel==len if dir=0.
- Beat: ser_valid & ser_ready.
  - A non-last beat steps mux_sel by -1 (dir=1) or +1 (dir=0).
  - The last beat returns the block to IDLE with load_ready<=1.
  - mux_sel is held at its final value on exit.
- Backpressure: with ser_ready=0, mux_sel, ser_data and ser_last hold stable and ser_valid stays 1.
- Throughput: (len+1) beats per word plus 1 idle cycle between words. A load is never accepted in the same cycle as a last beat.
- abort in SHIFT:
  - Next state is IDLE; ser_valid drops next cycle.
  - No ser_last is generated unless the current beat is itself last.
  - A beat handshaking in the same cycle as abort counts as delivered.
- mux_inp stays constant from load until the next load, including during abort and IDLE.
- Index never wraps: stepping stops at 0 or len. The sequence for len=31, dir=0 is 0..31; out-of-range stepping is impossible by construction.
- Async reset during SHIFT forces all reset values immediately. The partial word is discarded with no ser_last.
- X on load_data or mux_out must not corrupt state.

Decomposition:
- Shared include/package mux_scan_defs:
  - state encodings (IDLE=1'b0, SHIFT=1'b1);
  - SEL_W and WIDTH localparams, shared with the mux tree.
- One natural sub-module: mux_scan_counter.
  - Loadable up/down SEL_W counter with enable and terminal-detect.
  - Drives mux_sel and ser_last.
- The FSM and handshake stay in the top.

Test Plan:
1. Reset release, load 32'hA5A5_0F0F, len=31, dir=0, ser_ready=1 -> load_ready rises 1 cycle after reset; 32 beats carry bits 0..31 (1,1,1,1,0,0,0,0,…); ser_last only on beat 32; load_ready=1 one cycle later.
2. Load 32'h8000_0001, len=31, dir=1 -> first bit 1 (sel=31), then 30 zeros, last bit 1 at sel=0 with ser_last.
3. Load 32'h0000_0006, len=2, dir=0, ser_ready toggling 1,0,0,1,1 -> bits 0,1,1 delivered; sel and data held through stalls; ser_last on the third beat.
4. Load len=0 -> single beat with ser_valid=1 and ser_last=1 on the first SHIFT cycle; IDLE next cycle.
5. Abort after 5 beats of a 32-bit scan -> ser_valid=0 next cycle; no ser_last; load_ready=1; mux_inp unchanged; new load accepted the cycle after.
6. rst_n pulsed low mid-scan (sel=17) -> outputs zero asynchronously without a clock edge; after release, load_ready=1 on the first edge and a fresh scan starts at sel=0.
